// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx, the receive FIFO and its consumer.
// slave is the FIFO side; master is the environment driving words in and taking them out.
interface uart_rx_fifo_if #(
    parameter int width = 8
);
    logic [width-1:0] in_data;
    logic             in_ready;
    logic             can_receive;
    logic [width-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data,
        input  in_ready,
        output can_receive,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_ready,
        input  can_receive,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind uart_rx with first-word-fall-through output and sticky overflow.
// Optional saturating drop counter enabled by defining UART_RX_FIFO_DROP_CNT_EN.
//
// Handshake: a word is popped on a rising edge where out_valid && out_ready; uart_rx
// strobes in_ready for one cycle and must only rely on can_receive (=!full) for acceptance,
// although a word arriving while full is still taken if a pop frees a slot that same edge.
module uart_rx_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    uart_rx_fifo_if.slave              bus,
    output logic [$clog2(depth):0]     level,
    output logic                       overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
    output logic [15:0]                drop_count,
`endif
    input  logic                       clear_overflow
);
    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;

    assign full  = (level == lw'(depth));
    assign empty = (level == '0);
    assign pop   = !empty && bus.out_ready;
    assign push  = bus.in_ready && (!full || pop);
    assign drop  = bus.in_ready && full && !pop;

    // Outputs depend only on registered state; data is masked so reset shows zero.
    assign bus.out_valid   = !empty;
    assign bus.out_data    = empty ? '0 : mem[rd_ptr];
    assign bus.can_receive = !full;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + lw'(1);
                2'b01:   level <= level - lw'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (drop) begin
            if (clear_overflow) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clear_overflow) begin
            drop_count <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
    localparam int width = 8;
    localparam int depth = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        clear_overflow = 1'b0;
    logic [4:0]  level;
    logic        overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    uart_rx_fifo_if #(.width(width)) bus ();

    uart_rx_fifo #(.width(width), .depth(depth)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .bus            (bus),
        .level          (level),
        .overflow       (overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .clear_overflow (clear_overflow)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int max_level = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue capped at depth by rule
    logic [width-1:0] exp_q[$];
    logic             ovf_m;
    logic [15:0]      drop_m;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            ovf_m  = 1'b0;
            drop_m = 16'd0;
        end else begin
            bit did_pop;
            bit was_full;
            bit did_drop;
            was_full = (exp_q.size() == depth);
            did_pop  = (exp_q.size() != 0) && bus.out_ready;
            did_drop = bus.in_ready && was_full && !did_pop;
            if (did_pop) void'(exp_q.pop_front());
            if (bus.in_ready && !did_drop) exp_q.push_back(bus.in_data);
            if (did_drop) ovf_m = 1'b1;
            else if (clear_overflow) ovf_m = 1'b0;
            if (did_drop) drop_m = clear_overflow ? 16'd1 : (drop_m == 16'hFFFF ? drop_m : drop_m + 16'd1);
            else if (clear_overflow) drop_m = 16'd0;
        end
    end

    // Observed pops, for sequence checks in the directed scenarios
    logic [width-1:0] got_q[$];
    always @(posedge clock) begin
        if (resetn && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end

    // Scoreboard compare on the falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            check("cyc_level", 32'(level), 32'(exp_q.size()));
            check("cyc_can_receive", 32'(bus.can_receive), 32'(exp_q.size() != depth));
            check("cyc_data", 32'(bus.out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
            check("cyc_overflow", 32'(overflow), 32'(ovf_m));
`ifdef UART_RX_FIFO_DROP_CNT_EN
            check("cyc_drop_count", 32'(drop_count), 32'(drop_m));
`endif
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.in_data  = d;
        bus.in_ready = 1'b1;
        tick();
        bus.in_ready = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < depth; i++) push_word(8'(i));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        check("drain_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        int pushed;
        int cyc;
        bus.in_data   = '0;
        bus.in_ready  = 1'b0;
        bus.out_ready = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_en = 1'b1;

        // 1: idle after reset
        tick();
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_level", 32'(level), 32'd0);
        check("idle_can_receive", 32'(bus.can_receive), 32'd1);
        check("idle_overflow", 32'(overflow), 32'd0);
        check("idle_data", 32'(bus.out_data), 32'd0);

        // 2: single word, latency 1
        push_word(8'hA5);
        check("one_valid", 32'(bus.out_valid), 32'd1);
        check("one_data", 32'(bus.out_data), 32'hA5);
        check("one_level", 32'(level), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("one_pop_valid", 32'(bus.out_valid), 32'd0);
        check("one_pop_level", 32'(level), 32'd0);

        // 3: fill then drain in order
        fill16();
        check("full_level", 32'(level), 32'd16);
        check("full_can_receive", 32'(bus.can_receive), 32'd0);
        got_q.delete();
        bus.out_ready = 1'b1;
        tick();
        check("first_pop_can_receive", 32'(bus.can_receive), 32'd1);
        check("first_pop_level", 32'(level), 32'd15);
        drain();
        check("drain_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check("drain_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i));

        // 4: push into full with simultaneous pop
        fill16();
        bus.in_data   = 8'h55;
        bus.in_ready  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_ready  = 1'b0;
        bus.out_ready = 1'b0;
        check("pp_level", 32'(level), 32'd16);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_head", 32'(bus.out_data), 32'h01);
        got_q.delete();
        drain();
        check("pp_count", 32'(got_q.size()), 32'd16);
        check("pp_last", (got_q.size() == 16) ? 32'(got_q[15]) : 32'hDEAD, 32'h55);

        // 5: drop while full, clear, drop with clear
        fill16();
        push_word(8'h77);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_count_1", 32'(drop_count), 32'd1);
`endif
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clear_overflow", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("clear_drop_count", 32'(drop_count), 32'd0);
`endif
        bus.in_data    = 8'h78;
        bus.in_ready   = 1'b1;
        clear_overflow = 1'b1;
        tick();
        bus.in_ready   = 1'b0;
        clear_overflow = 1'b0;
        check("drop_clear_overflow", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_clear_count", 32'(drop_count), 32'd1);
`endif
        got_q.delete();
        drain();
        check("drop_drain_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check("drop_drain_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;

        // 6: asynchronous reset mid-stream
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        check("pre_reset_level", 32'(level), 32'd3);
        #2 resetn = 1'b0;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_valid", 32'(bus.out_valid), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        push_word(8'h3C);
        check("post_reset_data", 32'(bus.out_data), 32'h3C);
        check("post_reset_level", 32'(level), 32'd1);
        got_q.delete();
        drain();
        check("post_reset_first", (got_q.size() != 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h3C);

        // 7: wrap with random consumer gaps
        got_q.delete();
        max_level = 0;
        pushed = 0;
        cyc = 0;
        while ((pushed < 40 || got_q.size() < 40) && cyc < 3000) begin
            bit do_push;
            do_push       = (pushed < 40) && bus.can_receive;
            bus.in_ready  = do_push;
            bus.in_data   = 8'(pushed);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            tick();
            if (do_push) pushed++;
            cyc++;
        end
        bus.in_ready  = 1'b0;
        bus.out_ready = 1'b0;
        check("wrap_timeout", 32'(cyc < 3000), 32'd1);
        check("wrap_count", 32'(got_q.size()), 32'd40);
        for (int i = 0; i < 40; i++)
            check("wrap_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i));
        check("wrap_max_level", 32'(max_level <= 16), 32'd1);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
